// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    // Control states of the serial adder.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Smallest operand width the datapath supports.
    localparam int unsigned MIN_WIDTH = 2;

    // True when an operand width is usable by the block.
    function automatic bit width_ok(input int unsigned w);
        return w >= MIN_WIDTH;
    endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Single-bit combinational full adder reused as the serial datapath.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one bit per clock, LSB first, through one full-adder cell.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // Reject unusable widths at elaboration.
    generate
        if (!width_ok(WIDTH)) begin : g_width_check
            $error("serial_adder: WIDTH must be at least %0d", MIN_WIDTH);
        end
    endgenerate

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-2:0]   sum_sh_q, sum_sh_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic               fa_sum;
    logic               fa_cout;
    logic [WIDTH-1:0]   sum_shifted;

    fa_cell u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // New sum bit enters at the MSB; the low bit of this vector is the oldest retained bit.
    assign sum_shifted = {fa_sum, sum_sh_q};

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        sum_sh_d    = sum_sh_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        cout_d      = cout_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    sum_sh_d = '0;
                    carry_d  = cin;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                sum_sh_d = sum_shifted[WIDTH-1:1];
                carry_d  = fa_cout;
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    sum_d   = sum_shifted;
                    cout_d  = fa_cout;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            sum_sh_q    <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            sum_sh_q    <= sum_sh_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule
